// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit drives the request and address. Memory answers with an ack
// and the instruction word in the same cycle.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / PC stage for the multicycle core.
// This block holds the PC and fetches the word at PC over the imem req/ack bus.
// It latches that word into the instruction register and exposes the decoded
// fields. It also commits the next PC from the jump/jr/branch controls. A PC
// update that arrives while a fetch is outstanding is remembered and applied
// on the cycle after the fetch ends. That commit uses the newly latched
// instruction.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15            // 1..15 request cycles before timeout
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus,
  input  logic               fetch_req,
  input  logic               pc_update,
  input  logic               jump,
  input  logic               jr,
  input  logic               beq,
  input  logic               bne,
  input  logic               zero,
  input  logic [31:0]        rs_data,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm16,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               instr_valid,
  output logic               busy,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last value the wait counter takes before the request is abandoned.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      state_q;
  logic        req_q;
  logic        valid_q;
  logic        err_q;
  logic        pending_q;
  logic [3:0]  wait_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  logic [31:0] next_pc;
  logic        branch_taken;
  logic        commit;

  // Branch target: base plus the sign-extended word offset, wrapping mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return base + offset;
  endfunction

  assign pc_plus4     = pc_q + 32'd4;
  assign branch_taken = (beq & zero) | (bne & ~zero);

  // A commit happens outside REQ when either a fresh or a deferred update is present.
  assign commit = (state_q != REQ) && (pc_update || pending_q);

  // Next-PC selection from the latched instruction; never from imem_rdata.
  always_comb begin
    next_pc = pc_plus4;
    if (jump && jr) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = branch_target(pc_plus4, instr_q[15:0]);
    end
  end

  // Fetch FSM: owns the request, wait counter, IR, PC, pending commit and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      wait_q    <= 4'd0;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // The PC commits before a same-cycle request, so the request uses the new PC.
          if (commit) begin
            pc_q      <= next_pc;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
          end
          if (fetch_req) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            wait_q  <= 4'd0;
            valid_q <= 1'b0;
          end
        end

        REQ: begin
          // fetch_req is ignored here. pc_update is only remembered for later.
          if (pc_update) begin
            pending_q <= 1'b1;
          end
          // If the ack and the timeout arrive on the same edge, the ack wins.
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (wait_q == WAIT_LAST) begin
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign busy        = (state_q == REQ) | pending_q;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level reference model,
// per-cycle compare on the falling edge, directed scenarios with literal checks.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 4;
  localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fetch_req = 0, pc_update = 0, jump = 0, jr = 0, beq = 0, bne = 0, zero = 0;
  logic [31:0] rs_data = 0;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        instr_valid, busy, fetch_err;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fetch_req(fetch_req), .pc_update(pc_update), .jump(jump), .jr(jr),
    .beq(beq), .bne(bne), .zero(zero), .rs_data(rs_data),
    .instr(instr), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .busy(busy), .fetch_err(fetch_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_instr = 32'd0;
  bit          m_valid = 0, m_err = 0, m_open = 0, m_owed = 0;
  int          m_age   = 0;

  function automatic logic [31:0] model_next();
    logic [31:0] seq;
    int          off;
    seq = m_pc + 32'd4;
    if (jump && jr) return rs_data;
    if (jump) return (seq & 32'hF000_0000) | ({6'd0, m_instr[25:0]} << 2);
    if ((beq && zero) || (bne && !zero)) begin
      off = $signed(m_instr[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = 0; m_valid = 0; m_err = 0;
      m_open = 0; m_owed = 0; m_age = 0;
    end else if (m_open) begin
      m_age++;
      if (pc_update) m_owed = 1;
      if (bus.imem_ack) begin
        m_instr = bus.imem_rdata; m_valid = 1; m_open = 0;
      end else if (m_age >= MAX_WAIT) begin
        m_open = 0; m_err = 1; m_valid = 0;
      end
    end else begin
      if (pc_update || m_owed) begin
        m_pc = model_next(); m_valid = 0; m_owed = 0;
      end
      if (fetch_req) begin
        m_open = 1; m_age = 0; m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr", instr, m_instr);
    chk("opcode", opcode, m_instr[31:26]);
    chk("rs", rs, m_instr[25:21]);
    chk("rt", rt, m_instr[20:16]);
    chk("rd", rd, m_instr[15:11]);
    chk("funct", funct, m_instr[5:0]);
    chk("imm16", imm16, m_instr[15:0]);
    chk("instr_valid", instr_valid, m_valid);
    chk("imem_req", bus.imem_req, m_open);
    if (m_open) chk("imem_addr", bus.imem_addr, m_pc);
    chk("busy", busy, m_open || m_owed);
    chk("fetch_err", fetch_err, m_err);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    fetch_req = 0; pc_update = 0; jump = 0; jr = 0; beq = 0; bne = 0; zero = 0;
  endtask

  // One fetch: request, ack in the delay-th request cycle; returns cycles imem_req was high.
  task automatic do_fetch(input logic [31:0] word, input int delay, output int hi);
    hi = 0;
    fetch_req = 1; tick(); fetch_req = 0;
    for (int i = 1; i < delay; i++) begin
      if (bus.imem_req) hi++;
      tick();
    end
    if (bus.imem_req) hi++;
    bus.imem_ack = 1; bus.imem_rdata = word; tick();
    bus.imem_ack = 0; bus.imem_rdata = GARBAGE;
    if (bus.imem_req) hi++;
  endtask

  task automatic set_pc(input logic [31:0] v);
    jump = 1; jr = 1; rs_data = v; pc_update = 1; tick(); clear_ctl();
  endtask

  int hi;

  initial begin
    bus.imem_ack = 0; bus.imem_rdata = GARBAGE;
    repeat (2) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_busy", busy, 0);
    rst_n = 1; tick();

    // Reset asserted mid-fetch drops the request at once.
    fetch_req = 1; tick(); fetch_req = 0;
    chk("req_started", bus.imem_req, 1);
    tick();
    #2 rst_n = 0;
    #1;
    chk("async_req_drop", bus.imem_req, 0);
    chk("async_pc", pc, 32'h0);
    chk("async_err", fetch_err, 0);
    tick(); rst_n = 1;
    bus.imem_ack = 1; bus.imem_rdata = 32'h1234_5678; tick();
    bus.imem_ack = 0; bus.imem_rdata = GARBAGE;
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", instr_valid, 0);
    fetch_req = 1; tick(); fetch_req = 0;
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    chk("post_rst_req", bus.imem_req, 1);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0; tick(); bus.imem_ack = 0; bus.imem_rdata = GARBAGE;

    // lw with a 3-cycle ack delay.
    do_fetch(32'h8C22_0004, 3, hi);
    chk("lw_req_cycles", hi, 3);
    chk("lw_opcode", opcode, 6'h23);
    chk("lw_rs", rs, 5'd1);
    chk("lw_rt", rt, 5'd2);
    chk("lw_imm16", imm16, 16'h0004);
    chk("lw_valid", instr_valid, 1);

    // beq with offset -1 word.
    set_pc(32'h0000_0100);
    chk("setpc_100", pc, 32'h100);
    do_fetch(32'h1000_FFFF, 1, hi);
    chk("min_latency_req", hi, 1);
    beq = 1; zero = 1; pc_update = 1; tick(); clear_ctl();
    chk("beq_taken", pc, 32'h100);
    chk("pcupd_clears_valid", instr_valid, 0);
    beq = 1; zero = 0; pc_update = 1; tick(); clear_ctl();
    chk("beq_not_taken", pc, 32'h104);
    bne = 1; zero = 0; pc_update = 1; tick(); clear_ctl();
    chk("bne_taken", pc, 32'h104);

    // j and jr.
    set_pc(32'hF000_0010);
    do_fetch(32'h0800_0040, 2, hi);
    jump = 1; pc_update = 1; tick(); clear_ctl();
    chk("j_target", pc, 32'hF000_0100);
    jump = 1; jr = 1; rs_data = 32'h200; pc_update = 1; tick(); clear_ctl();
    chk("jr_target", pc, 32'h200);
    set_pc(32'h0000_0203);
    chk("jr_unaligned", pc, 32'h203);
    chk("jr_unaligned_plus4", pc_plus4, 32'h207);

    // Ack on the final allowed cycle beats the timeout.
    do_fetch(32'h2001_0005, MAX_WAIT, hi);
    chk("ack_at_limit_cycles", hi, MAX_WAIT);
    chk("ack_at_limit_noerr", fetch_err, 0);

    // Timeout with no ack.
    fetch_req = 1; tick(); fetch_req = 0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.imem_req) hi++;
      tick();
    end
    chk("timeout_req_cycles", hi, MAX_WAIT);
    chk("timeout_err", fetch_err, 1);
    chk("timeout_instr_kept", instr, 32'h2001_0005);
    do_fetch(32'h0000_0020, 2, hi);
    chk("err_sticky", fetch_err, 1);
    chk("after_err_valid", instr_valid, 1);

    // PC update during an outstanding fetch is deferred to the cycle after ack.
    set_pc(32'h0000_0400);
    fetch_req = 1; tick(); fetch_req = 0;
    pc_update = 1; tick(); pc_update = 0;
    chk("pend_busy", busy, 1);
    chk("pend_pc_hold", pc, 32'h400);
    tick();
    bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0020; tick();
    bus.imem_ack = 0; bus.imem_rdata = GARBAGE;
    chk("commit_cycle_pc", pc, 32'h400);
    chk("commit_cycle_busy", busy, 1);
    chk("commit_cycle_valid", instr_valid, 1);
    tick();
    chk("committed_pc", pc, 32'h404);
    chk("committed_busy", busy, 0);

    // Same-cycle update and request: the request addresses the new PC.
    fetch_req = 1; pc_update = 1; tick(); clear_ctl();
    chk("upd_req_addr", bus.imem_addr, 32'h408);
    chk("upd_req_req", bus.imem_req, 1);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0020; tick();
    bus.imem_ack = 0; bus.imem_rdata = GARBAGE;

    // Only reset clears the sticky error.
    rst_n = 0; tick();
    chk("final_rst_err", fetch_err, 0);
    chk("final_rst_pc", pc, 32'h0);
    rst_n = 1; tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
